// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and the writeback request bundle used by
// the writeback arbiter and its scoreboard.
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr_rd;
    logic [XLEN-1:0]       data_rd;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by decode reservations, cleared by register-file
// commits, with a newer reservation taking precedence over a same-cycle clear.
module rf_scoreboard
  import rv32_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] query_rs1,
  input  logic [REG_ADDR_W-1:0] query_rs2,
  input  logic [REG_ADDR_W-1:0] query_rd,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_addr] = 1'b0;
    if (set_valid) busy_d[set_addr] = 1'b1;
    // x0 never holds a pending write
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1 = busy_q[query_rs1];
  assign busy_rs2 = busy_q[query_rs2];
  assign busy_rd  = busy_q[query_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter (ALU over LSU) with a registered write port.
// Optional LSU anti-starvation is enabled by defining RF_WB_ARB_ANTISTARVE_EN.
module rf_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_addr_rd,
  input  logic [XLEN-1:0]       req0_data_rd,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_addr_rd,
  input  logic [XLEN-1:0]       req1_data_rd,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_addr_rd,
  output logic [XLEN-1:0]       rf_data_rd,
  input  logic                  reserve_valid,
  input  logic [REG_ADDR_W-1:0] reserve_addr,
  input  logic [REG_ADDR_W-1:0] query_rs1,
  input  logic [REG_ADDR_W-1:0] query_rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd
);

  if (CNT_W < $clog2(STARVE_LIMIT + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold STARVE_LIMIT");
  end

  wb_req_t req0, req1, granted;
  logic    grant0, grant1, force1, xfer;

  assign req0 = '{valid: req0_valid, addr_rd: req0_addr_rd, data_rd: req0_data_rd};
  assign req1 = '{valid: req1_valid, addr_rd: req1_addr_rd, data_rd: req1_data_rd};

`ifdef RF_WB_ARB_ANTISTARVE_EN
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  assign force1 = req1.valid && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!req1.valid || grant1) begin
      starve_d = '0;
    end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force1 = 1'b0;
`endif

  // Readies stay low during reset so nothing is accepted that would be lost
  assign grant0 = reset_n && req0.valid && !force1;
  assign grant1 = reset_n && req1.valid && !grant0;
  assign xfer   = grant0 || grant1;
  assign granted = grant0 ? req0 : req1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (xfer) begin
      rf_we_d   = (granted.addr_rd != REG_ZERO);
      rf_addr_d = granted.addr_rd;
      rf_data_d = granted.data_rd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_addr_rd      = rf_addr_q;
  assign rf_data_rd      = rf_data_q;

  rf_scoreboard u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_valid (reserve_valid && (reserve_addr != REG_ZERO)),
    .set_addr  (reserve_addr),
    .clr_valid (rf_we_q),
    .clr_addr  (rf_addr_q),
    .query_rs1 (query_rs1),
    .query_rs2 (query_rs2),
    .query_rd  (reserve_addr),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2),
    .busy_rd   (busy_rd)
  );

endmodule
